axis_pkt_gen: RTL and testbench
===============================

Name: axis_pkt_gen

Overview:
- AXI-Stream master-side packet generator: the transmitter that drives the s_* slave port of the stream register slice and downstream stream blocks.
- Emits a programmed number of packets, each of programmed beat length.
- Data follows an arithmetic pattern; m_tlast marks the last beat of each packet; a configurable idle gap separates packets.
- Used as the synthesizable stimulus source for stream pipelines and on-board loopback tests.

Parameters:
- DW, 8, stream data width.
- LW, 16, width of beat-length and gap configuration fields.
- NW, 16, width of packet-count field.
- STEP, 2, data increment per accepted beat.
- SEED, 0, data value of the first beat after start.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle run request; sampled only in IDLE.
- cfg_len  in  LW  beats per packet; 0 treated as 1.
- cfg_num_pkts  in  NW  packets per run; 0 means no beats.
- cfg_gap  in  LW  idle cycles between packets.
- busy  out  1  high from the cycle after start until the done pulse.
- done  out  1  one-cycle pulse at end of run.
- m_tdata  out  DW  stream data.
- m_tvalid  out  1  stream valid.
- m_tlast  out  1  last beat of packet.
- m_tready  in  1  downstream ready.

Behaviour:
- Reset:
  - rst sampled high: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, all counters 0, state IDLE.
  - Reset mid-packet drops m_tvalid immediately at that edge. This is the only permitted valid withdrawal.
- Configuration latch: cfg_* is captured on the start edge. Later changes to cfg_* do not affect a run in progress.
- States:
  - IDLE:
    - m_tvalid=0.
    - start=1 with cfg_num_pkts!=0: latch cfg, data=SEED, beat_cnt=0, pkt_cnt=0, go to SEND, busy=1. m_tvalid rises the cycle after start is sampled (latency 1).
    - start=1 with cfg_num_pkts==0: done pulses the next cycle, busy stays 0, no beats.
  - SEND:
    - m_tvalid=1.
    - m_tlast = (beat_cnt == len-1).
    - Handshake = m_tvalid & m_tready.
    - Without a handshake, m_tdata, m_tlast and m_tvalid hold stable (AXI-S rule).
    - On each handshake: data = data+STEP modulo 2^DW (wraps silently), beat_cnt++.
    - On a handshake with m_tlast=1:
      - beat_cnt=0, pkt_cnt++.
      - If this was the final packet: go to IDLE, m_tvalid=0, done=1 for one cycle, busy=0 in the same cycle as done.
      - Else if gap==0: stay in SEND; m_tvalid stays 1 (back-to-back packets).
      - Else: go to GAP, load gap_cnt=gap.
  - GAP:
    - m_tvalid=0 for exactly gap cycles; gap_cnt decrements each cycle.
    - Returns to SEND so that m_tvalid rises gap cycles after the last handshake's following cycle.
- Data continuity: data is not reset between packets and continues incrementing across the run.
- start while busy: ignored.
- m_tready high while m_tvalid=0: no effect.
- m_tready is used only for handshake qualification; there is no combinational path from m_tready to any output.
- Throughput: with m_tready held high and gap=0, one beat per cycle continuously.

Optional Feature:
- Macro: AXIS_PKT_GEN_PRBS_EN.
- Defined:
  - m_tdata comes from a DW-bit Fibonacci LFSR seeded with SEED (SEED==0 is forced to 1).
  - Taps: x^8+x^6+x^5+x^4+1 for DW=8; a maximal-length tap table for DW up to 32.
  - The LFSR advances one step per handshake only; STEP is unused.
- Undefined: incrementing-by-STEP pattern; no LFSR logic synthesized.

Test Plan:
- Basic run:
  - Stimulus: DW=8, STEP=2, SEED=0; len=4, num=2, gap=0; m_tready=1.
  - Response: 8 consecutive valid beats 0,2,4,6,8,10,12,14. m_tlast on 6 and 14. done one cycle after the 14 handshake; busy low in that same cycle.
- Backpressure:
  - Stimulus: same config; m_tready toggles 1,0,0,1,...
  - Response: data held stable through ready-low cycles; same 8-value sequence; no skipped or duplicated beats.
- Gap:
  - Stimulus: len=3, num=2, gap=3, m_tready=1.
  - Response: beats 0,2,4 (tlast on 4), then exactly 3 cycles with m_tvalid=0, then 6,8,10 (tlast on 10).
- Edge lengths and wrap:
  - Stimulus: SEED=250, len=4, num=1.
  - Response: 250,252,254,0 with tlast on 0.
  - Stimulus: len=0 and len=1, num=3.
  - Response: 3 beats, each with tlast=1.
  - Stimulus: num=0.
  - Response: done pulse with no valid beat.
- Reset mid-packet:
  - Stimulus: len=10; assert rst after the 3rd handshake; then restart.
  - Response: m_tvalid drops at the rst edge; busy=0; the next run restarts at SEED.
  - Stimulus: start during busy.
  - Response: ignored.
- PRBS (macro defined):
  - Stimulus: SEED=1, len=5, m_tready=1.
  - Response: first beats 1,2,4,8,17 per the tap polynomial, each advancing only on handshake.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits cfg_num_pkts packets of cfg_len beats with cfg_gap idle cycles between them.
// Define AXIS_PKT_GEN_PRBS_EN to replace the incrementing data pattern with a Fibonacci LFSR.
module axis_pkt_gen #(
  parameter int DW   = 8,
  parameter int LW   = 16,
  parameter int NW   = 16,
  parameter int STEP = 2,
  parameter int SEED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  input  logic [NW-1:0] cfg_num_pkts,
  input  logic [LW-1:0] cfg_gap,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] len_m1;
  logic [NW-1:0] num_m1;
  logic [LW-1:0] gap_q;
  logic [LW-1:0] beat_cnt;
  logic [NW-1:0] pkt_cnt;
  logic [LW-1:0] gap_cnt;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_next;
  logic          handshake;
  logic          last_beat;
  logic          final_pkt;

`ifdef AXIS_PKT_GEN_PRBS_EN
  // Maximal-length Fibonacci tap masks; bit k-1 set means tap x^k is used.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0003;
    endcase
  endfunction

  localparam logic [31:0]   TAP_ALL = tap_mask(DW);
  localparam logic [DW-1:0] TAPS    = TAP_ALL[DW-1:0];
  localparam logic [DW-1:0] SEED_V  = (DW'(SEED) == '0) ? DW'(1) : DW'(SEED);

  assign data_next = {data_q[DW-2:0], ^(data_q & TAPS)};
`else
  localparam logic [DW-1:0] SEED_V = DW'(SEED);
  localparam logic [DW-1:0] STEP_V = DW'(STEP);

  assign data_next = data_q + STEP_V;
`endif

  assign handshake = (state == ST_SEND) && m_tready;
  assign last_beat = (beat_cnt == len_m1);
  assign final_pkt = (pkt_cnt == num_m1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && (cfg_num_pkts != '0)) state_next = ST_SEND;
      ST_SEND: begin
        if (handshake && last_beat) begin
          if (final_pkt)         state_next = ST_IDLE;
          else if (gap_q != '0)  state_next = ST_GAP;
        end
      end
      ST_GAP:  if (gap_cnt == LW'(1)) state_next = ST_SEND;
      default: state_next = ST_IDLE;
    endcase
  end

  // Config is snapshotted on the start edge so a run ignores later cfg_* changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_m1   <= '0;
      num_m1   <= '0;
      gap_q    <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      gap_cnt  <= '0;
      data_q   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_num_pkts != '0) begin
              len_m1   <= (cfg_len == '0) ? '0 : cfg_len - LW'(1);
              num_m1   <= cfg_num_pkts - NW'(1);
              gap_q    <= cfg_gap;
              beat_cnt <= '0;
              pkt_cnt  <= '0;
              data_q   <= SEED_V;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (handshake) begin
            data_q <= data_next;
            if (last_beat) begin
              beat_cnt <= '0;
              pkt_cnt  <= pkt_cnt + NW'(1);
              gap_cnt  <= gap_q;
              if (final_pkt) done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + LW'(1);
            end
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt - LW'(1);
        default: ;
      endcase
    end
  end

  // Outputs derive only from registers, so m_tready never reaches them combinationally.
  always_comb begin
    m_tvalid = (state == ST_SEND);
    m_tlast  = (state == ST_SEND) && last_beat;
    m_tdata  = data_q;
    busy     = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen: table of run configurations plus reset and PRBS sequences.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_num_pkts = '0;
  logic [15:0] cfg_gap = '0;
  logic        m_tready = 1'b0;

  logic        busy1, done1, valid1, last1;
  logic [7:0]  data1;
  logic        busy2, done2, valid2, last2;
  logic [7:0]  data2;

  int passCount = 0;
  int checkCount = 0;

  logic [7:0] beatData[$];
  bit         beatLast[$];
  int gapLow, doneCycle, busyAtDone, firstValid, stallErr, busyEver, postValid, postDone, timedOut;

  typedef struct {
    string      name;
    int         len;
    int         num;
    int         gap;
    logic [3:0] rpat;
    bit         sel;
    int         poke;
    int         expBeats;
    int         expLasts;
    int         expGap;
    int         expDone;
    int         expLastData;
  } vec_t;

  vec_t vecs[8];

`ifdef AXIS_PKT_GEN_PRBS_EN
  localparam logic [7:0] SEED0 = 8'd1;
`else
  localparam logic [7:0] SEED0 = 8'd0;
`endif
  localparam logic [7:0] SEED250 = 8'd250;

  always #5 clk = ~clk;

  axis_pkt_gen #(.DW(8), .LW(16), .NW(16), .STEP(2), .SEED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts),
    .cfg_gap(cfg_gap), .busy(busy1), .done(done1), .m_tdata(data1), .m_tvalid(valid1),
    .m_tlast(last1), .m_tready(m_tready)
  );

  axis_pkt_gen #(.DW(8), .LW(16), .NW(16), .STEP(2), .SEED(250)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts),
    .cfg_gap(cfg_gap), .busy(busy2), .done(done2), .m_tdata(data2), .m_tvalid(valid2),
    .m_tlast(last2), .m_tready(m_tready)
  );

  function automatic logic [7:0] nxt(input logic [7:0] d);
`ifdef AXIS_PKT_GEN_PRBS_EN
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
    return d + 8'd2;
`endif
  endfunction

  task automatic checkOutput(input string nm, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // One run: start pulse in cycle 0, cfg scrambled afterwards, ready follows rpat, optional extra start at cycle poke.
  task automatic applyStimulus(input int len, input int num, input int gap, input logic [3:0] rpat,
                               input bit sel, input int poke);
    logic [7:0] d, pd;
    logic v, l, b, dn, pv, pr, pl;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    beatData.delete();
    beatLast.delete();
    gapLow = 0; doneCycle = -1; busyAtDone = -1; firstValid = -1; stallErr = 0;
    busyEver = 0; postValid = 0; postDone = 0; timedOut = 1;
    @(posedge clk); #1;
    cfg_len = 16'(len); cfg_num_pkts = 16'(num); cfg_gap = 16'(gap);
    start = 1'b1; m_tready = rpat[0];
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = (c == poke);
      cfg_len = 16'd7; cfg_num_pkts = 16'd9; cfg_gap = 16'd5;
      m_tready = rpat[c % 4];
      @(negedge clk);
      v  = sel ? valid2 : valid1;
      d  = sel ? data2  : data1;
      l  = sel ? last2  : last1;
      b  = sel ? busy2  : busy1;
      dn = sel ? done2  : done1;
      if (pv && !pr && (!v || d != pd || l != pl)) stallErr++;
      if (v && firstValid < 0) firstValid = c;
      if (b) busyEver = 1;
      if (b && !v) gapLow++;
      if (v && m_tready) begin
        beatData.push_back(d);
        beatLast.push_back(l);
      end
      pv = v; pr = m_tready; pd = d; pl = l;
      if (dn) begin
        doneCycle = c;
        busyAtDone = int'(b);
        timedOut = 0;
        break;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      m_tready = 1'b1;
      @(negedge clk);
      if (sel ? valid2 : valid1) postValid++;
      if (sel ? done2 : done1) postDone++;
    end
  endtask

  initial begin
    int lasts, dataErr, lastErr, effLen, expFirst;
    logic [7:0] exp;
    logic [7:0] prbsExp[5];

    vecs[0] = '{"basic",        4, 2, 0, 4'b1111, 1'b0,  3, 8, 2, 0,  9, 14};
    vecs[1] = '{"backpressure", 4, 2, 0, 4'b1001, 1'b0, -1, 8, 2, 0, 17, 14};
    vecs[2] = '{"gap3",         3, 2, 3, 4'b1111, 1'b0, -1, 6, 2, 3, 10, 10};
    vecs[3] = '{"wrap",         4, 1, 0, 4'b1111, 1'b1, -1, 4, 1, 0,  5,  0};
    vecs[4] = '{"len0",         0, 3, 0, 4'b1111, 1'b0, -1, 3, 3, 0,  4,  4};
    vecs[5] = '{"len1",         1, 3, 0, 4'b1111, 1'b0, -1, 3, 3, 0,  4,  4};
    vecs[6] = '{"num0",         4, 0, 0, 4'b1111, 1'b0, -1, 0, 0, 0,  1,  0};
    vecs[7] = '{"gap1",         2, 2, 1, 4'b1111, 1'b0, -1, 4, 2, 1,  6,  6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", int'(valid1), 0);
    checkOutput("reset_last",  int'(last1),  0);
    checkOutput("reset_data",  int'(data1),  0);
    checkOutput("reset_busy",  int'(busy1),  0);
    checkOutput("reset_done",  int'(done1),  0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].len, vecs[i].num, vecs[i].gap, vecs[i].rpat, vecs[i].sel, vecs[i].poke);
      effLen = (vecs[i].len == 0) ? 1 : vecs[i].len;
      exp = vecs[i].sel ? SEED250 : SEED0;
      lasts = 0; dataErr = 0; lastErr = 0;
      foreach (beatData[j]) begin
        if (beatData[j] != exp) dataErr++;
        if (beatLast[j] != ((j % effLen) == effLen - 1)) lastErr++;
        if (beatLast[j]) lasts++;
        exp = nxt(exp);
      end
      expFirst = (vecs[i].expBeats > 0) ? 1 : -1;
      checkOutput({vecs[i].name, "_timeout"},    timedOut, 0);
      checkOutput({vecs[i].name, "_beats"},      beatData.size(), vecs[i].expBeats);
      checkOutput({vecs[i].name, "_lasts"},      lasts, vecs[i].expLasts);
      checkOutput({vecs[i].name, "_gapcycles"},  gapLow, vecs[i].expGap);
      checkOutput({vecs[i].name, "_donecycle"},  doneCycle, vecs[i].expDone);
      checkOutput({vecs[i].name, "_busyatdone"}, busyAtDone, 0);
      checkOutput({vecs[i].name, "_firstvalid"}, firstValid, expFirst);
      checkOutput({vecs[i].name, "_stall"},      stallErr, 0);
      checkOutput({vecs[i].name, "_dataseq"},    dataErr, 0);
      checkOutput({vecs[i].name, "_lastpos"},    lastErr, 0);
      checkOutput({vecs[i].name, "_postvalid"},  postValid, 0);
      checkOutput({vecs[i].name, "_postdone"},   postDone, 0);
      checkOutput({vecs[i].name, "_busyever"},   busyEver, (vecs[i].num != 0) ? 1 : 0);
`ifndef AXIS_PKT_GEN_PRBS_EN
      if (vecs[i].expBeats > 0)
        checkOutput({vecs[i].name, "_lastdata"}, int'(beatData[beatData.size() - 1]), vecs[i].expLastData);
`endif
    end

    // Reset lands after the third handshake of a 10-beat packet.
    @(posedge clk); #1;
    cfg_len = 16'd10; cfg_num_pkts = 16'd1; cfg_gap = 16'd0; start = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    exp = nxt(nxt(nxt(SEED0)));
    checkOutput("prereset_valid", int'(valid1), 1);
    checkOutput("prereset_data",  int'(data1),  int'(exp));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("midreset_valid", int'(valid1), 0);
    checkOutput("midreset_busy",  int'(busy1),  0);
    checkOutput("midreset_data",  int'(data1),  0);
    checkOutput("midreset_last",  int'(last1),  0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(2, 1, 0, 4'b1111, 1'b0, -1);
    checkOutput("restart_beats", beatData.size(), 2);
    if (beatData.size() > 0)
      checkOutput("restart_seed", int'(beatData[0]), int'(SEED0));
    checkOutput("restart_done", doneCycle, 3);

`ifdef AXIS_PKT_GEN_PRBS_EN
    prbsExp = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd17};
    applyStimulus(5, 1, 0, 4'b1001, 1'b0, -1);
    checkOutput("prbs_beats", beatData.size(), 5);
    for (int j = 0; j < 5; j++)
      if (j < beatData.size()) checkOutput($sformatf("prbs_beat%0d", j), int'(beatData[j]), int'(prbsExp[j]));
`else
    prbsExp = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8};
    applyStimulus(5, 1, 0, 4'b1001, 1'b0, -1);
    checkOutput("inc_beats", beatData.size(), 5);
    for (int j = 0; j < 5; j++)
      if (j < beatData.size()) checkOutput($sformatf("inc_beat%0d", j), int'(beatData[j]), int'(prbsExp[j]));
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
